// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the fetch PC, issues one word read per
// cycle to a single-cycle-latency instruction memory, pairs each returned
// word with its PC and queues the pairs for decode behind a valid/ready port.
// A redirect flushes every speculative fetch and restarts at the new target.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);

   // Buffer depth is restricted to 2 or 4, so pointers wrap naturally.
   localparam int AW = (FIFO_DEPTH > 2) ? 2 : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   req_pc;
   logic          inflight;
   logic [31:0]   pc_buf    [FIFO_DEPTH];
   logic [31:0]   instr_buf [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] occupancy;
   logic          pop;
   logic          push;
   logic          issue;

   // The low two bits of a redirect target are dropped on purpose.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign imem_addr = fetch_pc;
   assign out_valid = (count != '0);
   assign out_pc    = out_valid ? pc_buf[rd_ptr]    : '0;
   assign out_instr = out_valid ? instr_buf[rd_ptr] : '0;

   assign pop  = out_valid & out_ready;
   assign push = inflight & ~redirect_valid;

   // Entries the buffer will hold once the outstanding read lands; only issue
   // when that still leaves room, so a returning word always has a slot.
   assign occupancy = count + CW'(inflight) - CW'(pop);
   assign issue     = ~redirect_valid & (occupancy < DEPTH_C);

   // Fetch PC, outstanding-request tracking and buffer bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (issue) begin
            fetch_pc <= fetch_pc + 32'd4;
            req_pc   <= fetch_pc;
         end
         inflight <= issue;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Buffer storage; contents are don't-care until counted as valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_buf[wr_ptr]    <= req_pc;
         instr_buf[wr_ptr] <= imem_rdata;
      end
   end

   // A push into a full buffer would overwrite the oldest unread entry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && (count == DEPTH_C)));
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a long randomized run.
// The reference model says that after reset or a redirect to T the decode
// side sees T, T+4, T+8, ... in order with instr == mem[pc]; a monitor pops
// those expectations whenever a handshake completes.
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   logic [31:0] addr_b;
   logic [31:0] rdata_b;
   logic        redir_b = 1'b0;
   logic [31:0] redir_pc_b = 32'h0;
   logic        valid_b;
   logic        ready_b = 1'b1;
   logic [31:0] pc_b;
   logic [31:0] instr_b;

   int passes = 0;
   int total  = 0;

   logic [63:0] exp_q[$];
   logic [31:0] next_pc;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RESET_PC_A), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr)
   );

   instr_fetch #(.RESET_PC(RESET_PC_B), .FIFO_DEPTH(4)) dut_wrap (
      .clk(clk), .rst(rst), .imem_addr(addr_b), .imem_rdata(rdata_b),
      .redirect_valid(redir_b), .redirect_pc(redir_pc_b),
      .out_valid(valid_b), .out_ready(ready_b),
      .out_pc(pc_b), .out_instr(instr_b)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
   endfunction

   // Single-cycle-latency memories.
   always @(posedge clk) begin
      imem_rdata <= mem_word(imem_addr);
      rdata_b    <= mem_word(addr_b);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passes++;
      else $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
   endtask

   // One clock of stimulus, then the model reacts to what was driven.
   task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] tgt);
      @(posedge clk); #1;
      rst            = r;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = tgt;
      @(negedge clk); #1;
      if (r) begin
         exp_q.delete();
         next_pc = RESET_PC_A;
      end else if (rv) begin
         exp_q.delete();
         next_pc = {tgt[31:2], 2'b00};
      end
      while (exp_q.size() < 8) begin
         exp_q.push_back({next_pc, mem_word(next_pc)});
         next_pc = next_pc + 32'd4;
      end
   endtask

   // Monitor: gap timing after reset/redirect, hold-while-stalled, zeros when
   // idle, and in-order delivery against the expectation queue.
   int          age = 1000;
   int          first_at = 0;
   logic        hold_prev = 1'b0;
   logic [31:0] hold_pc;
   logic [31:0] hold_instr;
   logic [63:0] e;

   always @(negedge clk) begin
      if (rst) begin
         age       = -1;
         first_at  = 2;
         hold_prev = 1'b0;
      end else begin
         if (age < 1000) age++;
         if (age >= 0 && age < first_at) check("gap_valid", {31'b0, out_valid}, 32'd0);
         if (age == first_at) check("first_valid", {31'b0, out_valid}, 32'd1);
         if (hold_prev) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_pc", out_pc, hold_pc);
            check("hold_instr", out_instr, hold_instr);
         end
         if (!out_valid) begin
            check("idle_pc", out_pc, 32'd0);
            check("idle_instr", out_instr, 32'd0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL sb_empty: actual pc %h required no output", out_pc);
            end else begin
               e = exp_q.pop_front();
               check("out_pc", out_pc, e[63:32]);
               check("out_instr", out_instr, e[31:0]);
            end
         end
         hold_prev  = out_valid && !out_ready && !redirect_valid;
         hold_pc    = out_pc;
         hold_instr = out_instr;
         if (redirect_valid) begin
            age      = 0;
            first_at = 3;
         end
      end
   end

   logic rdy_r;

   initial begin
      rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      next_pc = RESET_PC_A;

      // Reset release with decode always ready: first output in cycle 2, then
      // one per cycle. The second instance checks PC wrap from 0xFFFF_FFFC.
      step(1, 1, 0, 0); step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      check("wrap_addr0", addr_b, RESET_PC_B);
      step(0, 1, 0, 0);
      check("wrap_addr1", addr_b, 32'h0000_0000);
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 0, 0);
         check("stream_valid", {31'b0, out_valid}, 32'd1);
         check("stream_pc", out_pc, 32'(4 * k));
         if (k == 0) begin
            check("wrap_valid", {31'b0, valid_b}, 32'd1);
            check("wrap_pc", pc_b, RESET_PC_B);
            check("wrap_instr", instr_b, mem_word(RESET_PC_B));
         end
      end
      repeat (4) step(0, 1, 0, 0);

      // Decode stalled from reset: buffer fills, fetch stops, head holds.
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      repeat (10) step(0, 0, 0, 0);
      check("stall_addr", imem_addr, RESET_PC_A + 32'd8);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_pc", out_pc, RESET_PC_A);
      check("stall_instr", out_instr, mem_word(RESET_PC_A));
      repeat (8) step(0, 1, 0, 0);

      // Redirect coinciding with a pop from a full buffer.
      step(1, 0, 0, 0);
      repeat (8) step(0, 0, 0, 0);
      step(0, 1, 1, 32'h0000_0100);
      step(0, 1, 0, 0);
      check("flush_addr", imem_addr, 32'h0000_0100);
      check("flush_valid", {31'b0, out_valid}, 32'd0);
      repeat (6) step(0, 1, 0, 0);

      // Redirect to an unaligned target while streaming.
      step(0, 1, 1, 32'h0000_0043);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      check("redir_valid", {31'b0, out_valid}, 32'd1);
      check("redir_pc", out_pc, 32'h0000_0040);
      repeat (5) step(0, 1, 0, 0);

      // Randomized ready, redirects (including back-to-back and near the top
      // of the address space) and occasional resets.
      rdy_r = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         logic        r;
         logic        rv;
         logic [31:0] tgt;
         if ($urandom_range(0, 5) == 0) rdy_r = ~rdy_r;
         r   = ($urandom_range(0, 2999) == 0);
         rv  = !r && ($urandom_range(0, 39) == 0);
         tgt = $urandom;
         if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | {28'h0, tgt[3:0]};
         step(r, rdy_r, rv, tgt);
      end
      repeat (20) step(0, 1, 0, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
